// File: rtl/public_private_acc.sv
// Negacyclic polynomial accumulator: sums three-lane partial-product beats into
// DEPTH coefficients mod 2^18, then streams the finished polynomial out and clears it.
module public_private_acc #(
    parameter int DEPTH = 784,
    parameter int BEATS = (DEPTH / 2) * (DEPTH / 2)
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        B_valid,
    output logic        B_ready,
    input  logic [10:0] idx_B,
    input  logic [53:0] B_in,
    input  logic [9:0]  h_in,
    output logic        c_valid,
    input  logic        c_ready,
    output logic [9:0]  c_idx,
    output logic [17:0] c_out,
    output logic [9:0]  c_h,
    output logic        err
);

    // state | meaning
    // ACCUM | accepting beats into acc
    // DRAIN | streaming acc out one coefficient per handshake, zeroing each
    typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [11:0] DEPTH_K   = 12'(DEPTH);
    localparam logic [11:0] MAX_IDX   = 12'(2 * DEPTH - 4);
    localparam logic [17:0] LAST_BEAT = 18'(BEATS - 1);
    localparam logic [9:0]  LAST_COEF = 10'(DEPTH - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [17:0] r_acc [DEPTH];
    logic [17:0] r_cnt;
    logic [9:0]  r_c_idx;
    logic [9:0]  r_c_h;
    logic        r_err;

    logic          w_beat_hs;
    logic          w_idx_ok;
    logic          w_beat_ok;
    logic          w_last_beat;
    logic          w_coef_hs;
    logic          w_last_coef;
    logic [11:0]   w_k    [3];
    logic [11:0]   w_kred [3];
    logic          w_wrap [3];
    logic [AW-1:0] w_addr [3];
    logic [17:0]   w_lane [3];

    assign B_ready = (r_state == ACCUM);
    assign c_valid = (r_state == DRAIN);
    assign c_idx   = r_c_idx;
    assign c_h     = r_c_h;
    assign err     = r_err;
    assign c_out   = r_acc[r_c_idx[AW-1:0]];

    assign w_beat_hs   = B_valid & B_ready;
    assign w_idx_ok    = ~idx_B[0] && ({1'b0, idx_B} <= MAX_IDX);
    assign w_beat_ok   = w_beat_hs & w_idx_ok;
    assign w_last_beat = w_beat_ok && (r_cnt == LAST_BEAT);
    assign w_coef_hs   = c_valid & c_ready;
    assign w_last_coef = w_coef_hs && (r_c_idx == LAST_COEF);

    // Indices at or above DEPTH fold back with a sign flip (x^DEPTH == -1).
    always_comb begin
        for (int j = 0; j < 3; j++) begin
            w_k[j]    = {1'b0, idx_B} + 12'(j);
            w_wrap[j] = (w_k[j] >= DEPTH_K);
            w_kred[j] = w_wrap[j] ? (w_k[j] - DEPTH_K) : w_k[j];
            w_addr[j] = w_kred[j][AW-1:0];
            w_lane[j] = B_in[18*j +: 18];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_last_beat) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_coef) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= ACCUM;
            r_cnt   <= '0;
            r_c_idx <= '0;
            r_c_h   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_beat_hs && !w_idx_ok)
                r_err <= 1'b1;
            if (w_beat_ok) begin
                r_cnt <= w_last_beat ? '0 : r_cnt + 18'd1;
                if (r_cnt == '0)
                    r_c_h <= h_in;
            end
            if (w_coef_hs)
                r_c_idx <= w_last_coef ? '0 : r_c_idx + 10'd1;
        end
    end

    // Lane addresses within one beat are distinct, and beats never land during DRAIN.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int e = 0; e < DEPTH; e++)
                r_acc[e] <= '0;
        end else begin
            if (w_beat_ok) begin
                for (int j = 0; j < 3; j++)
                    r_acc[w_addr[j]] <= w_wrap[j] ? (r_acc[w_addr[j]] - w_lane[j])
                                                  : (r_acc[w_addr[j]] + w_lane[j]);
            end
            if (w_coef_hs)
                r_acc[r_c_idx[AW-1:0]] <= '0;
        end
    end

endmodule

// File: tb/tb_public_private_acc.sv
// Directed and table-driven bench for public_private_acc at DEPTH=8, BEATS=2.
module tb_public_private_acc;

    localparam int DEPTH = 8;
    localparam int BEATS = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        B_valid;
    logic        B_ready;
    logic [10:0] idx_B;
    logic [53:0] B_in;
    logic [9:0]  h_in;
    logic        c_valid;
    logic        c_ready;
    logic [9:0]  c_idx;
    logic [17:0] c_out;
    logic [9:0]  c_h;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    public_private_acc #(.DEPTH(DEPTH), .BEATS(BEATS)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .B_valid(B_valid),
        .B_ready(B_ready),
        .idx_B  (idx_B),
        .B_in   (B_in),
        .h_in   (h_in),
        .c_valid(c_valid),
        .c_ready(c_ready),
        .c_idx  (c_idx),
        .c_out  (c_out),
        .c_h    (c_h),
        .err    (err)
    );

    typedef struct packed {
        logic [10:0]      i0;
        logic [53:0]      b0;
        logic [10:0]      i1;
        logic [53:0]      b1;
        logic [9:0]       tag;
        logic [7:0][17:0] cf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, want);
        end
    endtask

    function automatic logic [53:0] ln(input logic [17:0] a, input logic [17:0] b,
                                       input logic [17:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [7:0][17:0] mk(input int e0, input int e1, input int e2,
                                            input int e3, input int e4, input int e5,
                                            input int e6, input int e7);
        logic [7:0][17:0] r;
        r[0] = e0[17:0]; r[1] = e1[17:0]; r[2] = e2[17:0]; r[3] = e3[17:0];
        r[4] = e4[17:0]; r[5] = e5[17:0]; r[6] = e6[17:0]; r[7] = e7[17:0];
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic beat(input logic [10:0] idx, input logic [53:0] d, input logic [9:0] tag);
        chk("b_ready_before_beat", 32'(B_ready), 32'd1);
        B_valid = 1'b1;
        idx_B   = idx;
        B_in    = d;
        h_in    = tag;
        @(posedge clk_in);
        @(negedge clk_in);
        B_valid = 1'b0;
    endtask

    task automatic drain(input logic [7:0][17:0] cf, input logic [9:0] tag, input string nm);
        chk({nm, "/c_valid_rise"}, 32'(c_valid), 32'd1);
        chk({nm, "/b_ready_fall"}, 32'(B_ready), 32'd0);
        c_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("%s/c_idx[%0d]", nm, i), 32'(c_idx), i);
            chk($sformatf("%s/c_out[%0d]", nm, i), 32'(c_out), 32'(cf[i]));
            chk($sformatf("%s/c_h[%0d]", nm, i), 32'(c_h), 32'(tag));
            @(posedge clk_in);
            @(negedge clk_in);
        end
        c_ready = 1'b0;
        chk({nm, "/c_valid_fall"}, 32'(c_valid), 32'd0);
        chk({nm, "/b_ready_rise"}, 32'(B_ready), 32'd1);
        chk({nm, "/c_idx_wrap"}, 32'(c_idx), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, wanted finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             pat[4];
        logic [7:0][17:0] m;
        logic [10:0]      ri [2];
        logic [53:0]      rd [2];
        logic [9:0]       rt;
        int               idx;
        int               cyc;
        int               k;
        logic [17:0]      lane;

        vecs[0] = '{i0: 11'd0, b0: ln(1, 2, 3), i1: 11'd4, b1: '0, tag: 10'h155,
                    cf: mk(1, 2, 3, 0, 0, 0, 0, 0)};
        vecs[1] = '{i0: 11'd6, b0: ln(5, 7, 9), i1: 11'd0, b1: ln(10, 0, 0), tag: 10'h02A,
                    cf: mk(1, 0, 0, 0, 0, 0, 5, 7)};
        vecs[2] = '{i0: 11'd6, b0: ln(5, 7, 2), i1: 11'd0, b1: '0, tag: 10'h003,
                    cf: mk(32'h3FFFE, 0, 0, 0, 0, 0, 5, 7)};
        vecs[3] = '{i0: 11'd0, b0: ln(1, 1, 1), i1: 11'd2, b1: ln(1, 1, 1), tag: 10'h3FF,
                    cf: mk(1, 1, 2, 1, 1, 0, 0, 0)};
        vecs[4] = '{i0: 11'd12, b0: ln(18'h3FFFF, 1, 4), i1: 11'd4, b1: ln(1, 1, 1),
                    tag: 10'h100, cf: mk(0, 0, 0, 0, 2, 0, 32'h3FFFD, 0)};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_in  = 1'b0;
        B_valid = 1'b0;
        idx_B   = '0;
        B_in    = '0;
        h_in    = '0;
        c_ready = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst/b_ready", 32'(B_ready), 32'd1);
        chk("rst/c_valid", 32'(c_valid), 32'd0);
        chk("rst/err", 32'(err), 32'd0);
        chk("rst/c_idx", 32'(c_idx), 32'd0);
        chk("rst/c_h", 32'(c_h), 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("idle/b_ready", 32'(B_ready), 32'd1);
        chk("idle/c_valid", 32'(c_valid), 32'd0);

        // Second beat carries a different tag: c_h must come from the first.
        for (int v = 0; v < 5; v++) begin
            beat(vecs[v].i0, vecs[v].b0, vecs[v].tag);
            beat(vecs[v].i1, vecs[v].b1, ~vecs[v].tag);
            drain(vecs[v].cf, vecs[v].tag, $sformatf("vec%0d", v));
        end

        // Backpressure: c_ready pattern 1,0,0,1 repeating.
        beat(vecs[0].i0, vecs[0].b0, 10'h011);
        beat(vecs[0].i1, vecs[0].b1, 10'h022);
        idx = 0;
        cyc = 0;
        while (idx < DEPTH && cyc < 40) begin
            c_ready = pat[cyc % 4];
            chk("bp/c_valid", 32'(c_valid), 32'd1);
            chk($sformatf("bp/c_idx@%0d", cyc), 32'(c_idx), idx);
            chk($sformatf("bp/c_out@%0d", cyc), 32'(c_out), 32'(vecs[0].cf[idx]));
            chk("bp/c_h", 32'(c_h), 32'h011);
            @(posedge clk_in);
            @(negedge clk_in);
            if (c_ready) idx++;
            cyc++;
        end
        c_ready = 1'b0;
        chk("bp/all_drained", idx, DEPTH);
        chk("bp/c_valid_fall", 32'(c_valid), 32'd0);
        beat(vecs[0].i0, vecs[0].b0, 10'h033);
        beat(vecs[0].i1, vecs[0].b1, 10'h044);
        drain(vecs[0].cf, 10'h033, "bp_repeat");

        // Illegal index: flagged, not accumulated, not counted, no tag latch.
        B_valid = 1'b1;
        idx_B   = 11'd14;
        B_in    = ln(9, 9, 9);
        h_in    = 10'h0AA;
        @(posedge clk_in);
        @(negedge clk_in);
        B_valid = 1'b0;
        chk("ill/err", 32'(err), 32'd1);
        chk("ill/b_ready", 32'(B_ready), 32'd1);
        beat(11'd0, ln(7, 0, 0), 10'h0CC);
        chk("ill/not_counted_b_ready", 32'(B_ready), 32'd1);
        chk("ill/not_counted_c_valid", 32'(c_valid), 32'd0);
        beat(11'd2, '0, 10'h0DD);
        chk("ill/err_sticky", 32'(err), 32'd1);
        drain(mk(7, 0, 0, 0, 0, 0, 0, 0), 10'h0CC, "ill");

        // Reset in the middle of a drain.
        beat(vecs[1].i0, vecs[1].b0, 10'h055);
        beat(vecs[1].i1, vecs[1].b1, 10'h066);
        c_ready = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        c_ready = 1'b0;
        chk("mid/c_idx", 32'(c_idx), 32'd2);
        rst_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("mrst/b_ready", 32'(B_ready), 32'd1);
        chk("mrst/c_valid", 32'(c_valid), 32'd0);
        chk("mrst/err", 32'(err), 32'd0);
        chk("mrst/c_idx", 32'(c_idx), 32'd0);
        chk("mrst/c_h", 32'(c_h), 32'd0);
        chk("mrst/c_out", 32'(c_out), 32'd0);
        rst_in = 1'b1;
        beat(vecs[3].i0, vecs[3].b0, vecs[3].tag);
        beat(vecs[3].i1, vecs[3].b1, 10'h000);
        drain(vecs[3].cf, vecs[3].tag, "post_rst");

        // Random legal products against a negacyclic reference.
        for (int r = 0; r < 12; r++) begin
            m  = '0;
            rt = 10'($urandom);
            for (int b = 0; b < 2; b++) begin
                ri[b] = 11'(2 * $urandom_range(0, DEPTH - 2));
                rd[b] = {18'($urandom), 18'($urandom), 18'($urandom)};
                for (int j = 0; j < 3; j++) begin
                    k    = int'(ri[b]) + j;
                    lane = rd[b][18*j +: 18];
                    if (k < DEPTH) m[k] = m[k] + lane;
                    else           m[k - DEPTH] = m[k - DEPTH] - lane;
                end
            end
            beat(ri[0], rd[0], rt);
            beat(ri[1], rd[1], ~rt);
            drain(m, rt, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/public_private_acc.md
# public_private_acc

Accumulates the 54-bit partial-product beats produced by the public/private multiply stage into one DEPTH-coefficient polynomial. The polynomial is reduced mod x^DEPTH + 1 (negacyclic) with coefficients mod 2^18. After a fixed number of beats, the block streams the finished polynomial out one coefficient per handshake, clears it, and re-arms for the next product. It sits directly downstream of the multiply stage and upstream of the ciphertext packer.

## Interface
- DEPTH, 784, polynomial length; must be even.
- BEATS, (DEPTH/2)*(DEPTH/2), beats accepted per product before drain.
- clk_in  input  1  single clock; all state changes on its rising edge.
- rst_in  input  1  synchronous, active-low reset.
- B_valid  input  1  upstream beat valid.
- B_ready  output  1  block can accept a beat.
- idx_B  input  11  base index of the beat; legal range 0..2*DEPTH-4, even.
- B_in  input  54  three 18-bit lanes; lane j = B_in[18j+17:18j] targets index idx_B+j.
- h_in  input  10  row tag accompanying each beat.
- c_valid  output  1  output coefficient valid.
- c_ready  input  1  downstream accepts coefficient.
- c_idx  output  10  index of coefficient on c_out (0..DEPTH-1).
- c_out  output  18  coefficient value.
- c_h  output  10  tag latched from the first beat of the product.
- err  output  1  sticky; set on any accepted beat with an illegal idx_B.

## Operation
- Storage: acc[0..DEPTH-1], 18 bits each, held in registers. All lanes update in the same cycle, so back-to-back beats with overlapping indices have no hazard.
- States: ACCUM, DRAIN.
- ACCUM:
  - B_ready=1, c_valid=0.
  - On B_valid&B_ready, for each lane j, with k=idx_B+j:
    - if k<DEPTH: acc[k] += lane_j (mod 2^18);
    - else: acc[k-DEPTH] -= lane_j (mod 2^18).
  - The three target addresses of one beat are always distinct.
- Beat counter cnt (18 bits) counts accepted beats. The first accepted beat (cnt==0) latches h_in into c_h.
- The accept with cnt==BEATS-1 moves to DRAIN and clears cnt.
- Illegal beat (idx_B odd or >2*DEPTH-4): err<=1. The beat is otherwise dropped: no acc update and no count.
- DRAIN:
  - B_ready=0, c_valid=1, c_out=acc[c_idx].
  - On c_valid&c_ready: acc[c_idx]<=0 and c_idx++.
  - The handshake at c_idx==DEPTH-1 returns to ACCUM with c_idx<=0.
- c_h holds its value until the next product's first beat.

## Timing
- Reset (rst_in==0 at a clock edge): state=ACCUM, all acc=0, cnt=0, c_idx=0, c_h=0, err=0, c_valid=0, B_ready=1.
  - Reset mid-accumulation or mid-drain discards all partial results.
- B_ready and c_valid are registered state decodes.
  - B_ready falls in the cycle after the final beat is accepted.
  - c_valid rises in that same cycle.
- Drain accept to ACCUM:
  - c_valid falls in the cycle after the last coefficient handshake.
  - B_ready rises in that same cycle.
  - A beat presented then is accepted against an all-zero acc.
- Accumulate latency: a beat accepted in cycle t is visible in acc at t+1.
  - The final beat is therefore included in coefficient 0 on the first DRAIN cycle.
- Drain throughput: one coefficient per cycle with c_ready held high, so a full drain takes DEPTH cycles.
- While c_valid&!c_ready: c_idx, c_out and c_h hold stable.
- Beats presented while B_ready=0 are not accepted; upstream must hold them.
- No combinational path from B_valid to B_ready, or from c_ready to c_valid.

## Test plan
- Reset then idle:
  - Expect B_ready=1, c_valid=0, err=0.
  - Reset with DEPTH=8, BEATS=1; send idx_B=0, B_in lanes {1,2,3}.
  - Expect drain to output c_out 1,2,3,0,0,0,0,0 at c_idx 0..7, with c_h equal to the tag sent.
- Negacyclic wrap:
  - DEPTH=8, BEATS=2; beats idx_B=6 lanes {5,7,9}, then idx_B=0 lanes {10,0,0}.
  - Expect acc[6]=5, acc[7]=7, acc[0]=10-9=1.
  - Also test lane {5,7,2}, which gives acc[0]=0x3FFFE (2^18-2) before adding 0; this covers modulo wrap.
- Back-to-back overlap:
  - DEPTH=8, BEATS=2; consecutive-cycle beats idx_B=0 lanes {1,1,1} and idx_B=2 lanes {1,1,1}.
  - Expect acc = 1,1,2,1,1,0,0,0.
- Drain backpressure: toggle c_ready 1,0,0,1.
  - Expect c_idx/c_out to hold during the low cycles, each coefficient output exactly once, and all acc=0 afterwards.
  - A second identical product must reproduce the same output.
- Illegal index and reset: idx_B=2*DEPTH-2 gives err=1 and no count increment. Then assert rst_in=0 mid-DRAIN: expect all outputs back to reset values and err=0.
- Full DEPTH=784 run:
  - Drive 153664 beats from a reference model of A×s for random A and a binary s.
  - Compare all 784 drained coefficients against the model.
